// File: rtl/bcd_time_if.sv
// bcd_time_if: control, preset and time/pulse signals of the BCD time-of-day counter.
// ALARM_EN adds the alarm compare inputs and the alarm output.
interface bcd_time_if;
  logic       sec_in_i;
  logic       en_i;
  logic       load_i;
  logic [7:0] ld_hh_i;
  logic [7:0] ld_mm_i;
  logic [7:0] ld_ss_i;
  logic [7:0] hh_o;
  logic [7:0] mm_o;
  logic [7:0] ss_o;
  logic       sec_tick_o;
  logic       min_wrap_o;
  logic       day_wrap_o;
  logic       load_err_o;
`ifdef ALARM_EN
  logic [7:0] alm_hh_i;
  logic [7:0] alm_mm_i;
  logic [0:0] alm_arm_i;
  logic [0:0] alarm_o;
  modport master (output sec_in_i, en_i, load_i, ld_hh_i, ld_mm_i, ld_ss_i, alm_hh_i, alm_mm_i, alm_arm_i,
                  input hh_o, mm_o, ss_o, sec_tick_o, min_wrap_o, day_wrap_o, load_err_o, alarm_o);
  modport slave (input sec_in_i, en_i, load_i, ld_hh_i, ld_mm_i, ld_ss_i, alm_hh_i, alm_mm_i, alm_arm_i,
                 output hh_o, mm_o, ss_o, sec_tick_o, min_wrap_o, day_wrap_o, load_err_o, alarm_o);
`else
  modport master (output sec_in_i, en_i, load_i, ld_hh_i, ld_mm_i, ld_ss_i,
                  input hh_o, mm_o, ss_o, sec_tick_o, min_wrap_o, day_wrap_o, load_err_o);
  modport slave (input sec_in_i, en_i, load_i, ld_hh_i, ld_mm_i, ld_ss_i,
                 output hh_o, mm_o, ss_o, sec_tick_o, min_wrap_o, day_wrap_o, load_err_o);
`endif
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: BCD HH:MM:SS counter advanced by rising edges of a 1 Hz square wave, with preset.
// Define ALARM_EN to add the registered HH:MM alarm compare.
module bcd_time_counter #(
  parameter int MAX_HOUR = 23,
  parameter int MAX_MIN  = 59
) (
  input logic clk,
  input logic clr,
  bcd_time_if.slave tc
);
  typedef enum logic {RUN, PRESET} state_t;
  localparam logic [7:0] HMAX = 8'((MAX_HOUR / 10) * 16 + MAX_HOUR % 10);
  localparam logic [7:0] MMAX = 8'((MAX_MIN / 10) * 16 + MAX_MIN % 10);
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    bcd_inc = (v == max) ? 9'h100 :
              (v[3:0] == 4'd9) ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction
  function automatic logic legal(input logic [7:0] v, input logic [7:0] max);
    legal = v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max;
  endfunction
  state_t     state_q, state_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       sec_q, tick_q, tick_d, mwrap_q, mwrap_d, dwrap_q, dwrap_d, err_q, err_d;
  logic [8:0] s_inc, m_inc, h_inc;
  logic       preset, rise, lh, lm, ls;
  always_comb begin
    state_d = tc.load_i ? PRESET : (state_q == PRESET ? RUN : state_q);
    preset  = state_d == PRESET;
    rise    = tc.sec_in_i & ~sec_q & tc.en_i;
    s_inc   = bcd_inc(ss_q, MMAX);
    m_inc   = bcd_inc(mm_q, MMAX);
    h_inc   = bcd_inc(hh_q, HMAX);
    lh      = legal(tc.ld_hh_i, HMAX);
    lm      = legal(tc.ld_mm_i, MMAX);
    ls      = legal(tc.ld_ss_i, MMAX);
    tick_d  = ~preset & rise;
    mwrap_d = tick_d & s_inc[8];
    dwrap_d = mwrap_d & m_inc[8] & h_inc[8];
    err_d   = preset & ~(lh & lm & ls);
    ss_d    = preset ? (ls ? tc.ld_ss_i : 8'h00) : tick_d ? s_inc[7:0] : ss_q;
    mm_d    = preset ? (lm ? tc.ld_mm_i : 8'h00) : mwrap_d ? m_inc[7:0] : mm_q;
    hh_d    = preset ? (lh ? tc.ld_hh_i : 8'h00) : (mwrap_d & m_inc[8]) ? h_inc[7:0] : hh_q;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= RUN;
      {hh_q, mm_q, ss_q} <= '0;
      {sec_q, tick_q, mwrap_q, dwrap_q, err_q} <= '0;
    end else begin
      state_q <= state_d;
      {hh_q, mm_q, ss_q} <= {hh_d, mm_d, ss_d};
      {sec_q, tick_q, mwrap_q, dwrap_q, err_q} <= {tc.sec_in_i, tick_d, mwrap_d, dwrap_d, err_d};
    end
  end
  assign tc.hh_o       = hh_q;
  assign tc.mm_o       = mm_q;
  assign tc.ss_o       = ss_q;
  assign tc.sec_tick_o = tick_q;
  assign tc.min_wrap_o = mwrap_q;
  assign tc.day_wrap_o = dwrap_q;
  assign tc.load_err_o = err_q;
`ifdef ALARM_EN
  logic alarm_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) alarm_q <= 1'b0;
    else alarm_q <= tc.alm_arm_i[0] && hh_q == tc.alm_hh_i && mm_q == tc.alm_mm_i;
  end
  assign tc.alarm_o = alarm_q;
`endif
endmodule
